// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator command dispatcher.
package calc_pkg;
    localparam int CALC_DW         = 4;
    localparam int CALC_DEPTH      = 4;
    localparam int CALC_WAIT_LIMIT = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } disp_state_e;
endpackage

// File: rtl/calc_cmd_dispatcher_if.sv
// Command, calculator and result channels of the dispatcher.
// slave = dispatcher view, master = producer/calculator/consumer view.
interface calc_cmd_dispatcher_if import calc_pkg::*; #(
    parameter int DEPTH = CALC_DEPTH,
    parameter int DW    = CALC_DW
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_x;
    logic [DW-1:0] cmd_y;

    logic          go_calc;
    logic [1:0]    calc_op;
    logic [DW-1:0] calc_x;
    logic [DW-1:0] calc_y;
    logic          calc_done;
    logic [DW-1:0] calc_out;

    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [1:0]    res_op;

    logic [CW-1:0] count;
    logic          timeout_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, calc_done, calc_out, res_ready,
        output cmd_ready, go_calc, calc_op, calc_x, calc_y,
               res_valid, res_data, res_op, count, timeout_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, calc_done, calc_out, res_ready,
        input  cmd_ready, go_calc, calc_op, calc_x, calc_y,
               res_valid, res_data, res_op, count, timeout_err
    );
endinterface

// File: rtl/calc_cmd_fifo.sv
// Purpose: DEPTH-entry command FIFO, head shown combinationally (zero when empty).
// Latency: a push is visible at head/count one edge later.
// Backpressure: push ignored when full, pop ignored when empty.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/calc_cmd_dispatcher.sv
// Purpose: queue (op,x,y) commands and run them one at a time on the calculator.
// Latency: push at edge k -> go_calc during k+1..k+2; result valid from the done edge.
// Backpressure: cmd_ready = FIFO not full; nothing is issued while a result waits in HOLD.
module calc_cmd_dispatcher import calc_pkg::*; #(
    parameter int DEPTH      = CALC_DEPTH,
    parameter int DW         = CALC_DW,
    parameter int WAIT_LIMIT = CALC_WAIT_LIMIT
) (
    input logic                  clk,
    input logic                  rst,
    calc_cmd_dispatcher_if.slave bus
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int EW  = 2 + 2 * DW;
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    disp_state_e    state;
    disp_state_e    state_nxt;
    logic [CW-1:0]  count;
    logic [EW-1:0]  head;
    logic           push;
    logic           pop;
    logic           done_ev;
    logic           timeout_ev;
    logic           wait_hit;
    logic [WCW-1:0] wait_cnt;
    logic           go_calc;
    logic           res_valid;
    logic [DW-1:0]  res_data;
    logic [1:0]     res_op;
    logic           timeout_err;

    assign bus.cmd_ready = (count < CW'(DEPTH));
    assign push          = bus.cmd_valid & bus.cmd_ready;

    calc_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.cmd_op, bus.cmd_x, bus.cmd_y}),
        .head  (head),
        .count (count)
    );

    assign {bus.calc_op, bus.calc_x, bus.calc_y} = head;

    // Done takes priority over a timeout landing on the same edge.
    assign wait_hit   = (wait_cnt == WCW'(WAIT_LIMIT - 1));
    assign done_ev    = (state == ST_WAIT) && bus.calc_done;
    assign timeout_ev = (state == ST_WAIT) && !bus.calc_done && wait_hit;
    assign pop        = done_ev | timeout_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_calc   = 1'b0;
        res_valid = 1'b0;
        unique case (state)
            ST_IDLE:  if (count != '0) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                go_calc   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.calc_done)  state_nxt = ST_HOLD;
                else if (wait_hit)  state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            res_data    <= '0;
            res_op      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + WCW'(1);
            if (done_ev) begin
                res_data <= bus.calc_out;
                res_op   <= bus.calc_op;
            end
            if (timeout_ev) timeout_err <= 1'b1;
        end
    end

    assign bus.go_calc     = go_calc;
    assign bus.res_valid   = res_valid;
    assign bus.res_data    = res_data;
    assign bus.res_op      = res_op;
    assign bus.count       = count;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_calc_cmd_dispatcher.sv
// Bench for calc_cmd_dispatcher: behavioural calculator stub, result scoreboard,
// vector table for single ops, hand-written sequences for timing corners.
module tb_calc_cmd_dispatcher;
    localparam int DEPTH      = 4;
    localparam int DW         = 4;
    localparam int WAIT_LIMIT = 16;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
    } sb_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   go_total;
    int   go_edges[$];
    logic prev_go;
    sb_t  exp_q[$];
    sb_t  e;

    logic          stub_en;
    int            stub_lat;
    logic          stub_busy;
    int            stub_cnt;
    logic [1:0]    s_op;
    logic [DW-1:0] s_x;
    logic [DW-1:0] s_y;

    calc_cmd_dispatcher_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    calc_cmd_dispatcher #(
        .DEPTH      (DEPTH),
        .DW         (DW),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] calc_fn(input logic [1:0] op, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
        case (op)
            2'd0:    calc_fn = x + y;
            2'd1:    calc_fn = x - y;
            2'd2:    calc_fn = x & y;
            default: calc_fn = x ^ y;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Calculator stub: latches operands on go_calc, pulses done stub_lat cycles into WAIT.
    initial begin
        bus.calc_done = 1'b0;
        bus.calc_out  = '0;
        stub_busy     = 1'b0;
        stub_cnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.calc_done = 1'b0;
            if (rst) begin
                stub_busy = 1'b0;
            end else begin
                if (stub_busy) begin
                    if (stub_cnt == 0) begin
                        bus.calc_done = 1'b1;
                        bus.calc_out  = calc_fn(s_op, s_x, s_y);
                        stub_busy     = 1'b0;
                    end else begin
                        stub_cnt--;
                    end
                end
                if (stub_en && bus.go_calc) begin
                    stub_busy = 1'b1;
                    stub_cnt  = stub_lat;
                    s_op      = bus.calc_op;
                    s_x       = bus.calc_x;
                    s_y       = bus.calc_y;
                end
            end
        end
    end

    // Monitor: go_calc pulse width/count and scoreboard compare on result handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_go = 1'b0;
        end else begin
            if (bus.go_calc) begin
                go_total++;
                go_edges.push_back(cyc);
                chk("go_width", {31'd0, prev_go}, 0);
            end
            prev_go = bus.go_calc;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_unexpected data=%0d op=%0d expected no result", bus.res_data, bus.res_op);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", {28'd0, bus.res_data}, {28'd0, e.data});
                    chk("res_op", {30'd0, bus.res_op}, {30'd0, e.op});
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, {29'd0, bus.count}, 0);
        chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 1);
        chk({tag, "_go_calc"}, {31'd0, bus.go_calc}, 0);
        chk({tag, "_calc_op"}, {30'd0, bus.calc_op}, 0);
        chk({tag, "_calc_x"}, {28'd0, bus.calc_x}, 0);
        chk({tag, "_calc_y"}, {28'd0, bus.calc_y}, 0);
        chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 0);
        chk({tag, "_res_data"}, {28'd0, bus.res_data}, 0);
        chk({tag, "_res_op"}, {30'd0, bus.res_op}, 0);
        chk({tag, "_timeout_err"}, {31'd0, bus.timeout_err}, 0);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic scored, input logic [DW-1:0] exp);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept_in_time", {31'd0, (n < 200)}, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (scored) exp_q.push_back(sb_t'{op: op, data: exp});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.count != 0 || bus.res_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {31'd0, (n < 300)}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global time limit");
    end

    initial begin
        vec_t tbl[6];
        int   g0;
        int   n;
        int   acc;
        int   maxc;

        checks = 0; failures = 0; cyc = 0; go_total = 0; prev_go = 1'b0;
        tbl[0] = '{op: 2'd0, x: 4'd12, y: 4'd2,  exp: 4'd14};
        tbl[1] = '{op: 2'd1, x: 4'd3,  y: 4'd5,  exp: 4'd14};
        tbl[2] = '{op: 2'd2, x: 4'd12, y: 4'd10, exp: 4'd8};
        tbl[3] = '{op: 2'd3, x: 4'd12, y: 4'd10, exp: 4'd6};
        tbl[4] = '{op: 2'd0, x: 4'd15, y: 4'd1,  exp: 4'd0};
        tbl[5] = '{op: 2'd1, x: 4'd0,  y: 4'd1,  exp: 4'd15};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.res_ready = 1'b0;
        stub_en = 1'b1; stub_lat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.res_ready = 1'b1;

        // Issue latency and result timing on an empty, idle dispatcher.
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_x = 4'd5; bus.cmd_y = 4'd3;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        exp_q.push_back(sb_t'{op: 2'd3, data: 4'd6});
        @(negedge clk);
        chk("lat_k_go", {31'd0, bus.go_calc}, 0);
        chk("lat_k_count", {29'd0, bus.count}, 1);
        @(negedge clk);
        chk("lat_k1_go", {31'd0, bus.go_calc}, 1);
        chk("lat_k1_calc_op", {30'd0, bus.calc_op}, 3);
        chk("lat_k1_calc_x", {28'd0, bus.calc_x}, 5);
        chk("lat_k1_calc_y", {28'd0, bus.calc_y}, 3);
        @(negedge clk);
        chk("lat_k2_go", {31'd0, bus.go_calc}, 0);
        chk("lat_k2_res_valid", {31'd0, bus.res_valid}, 0);
        @(negedge clk);
        chk("lat_k3_res_valid", {31'd0, bus.res_valid}, 1);
        @(posedge clk);
        #1;
        drain("lat_drain");

        // Single ops from the vector table, varying calculator latency.
        for (int i = 0; i < 6; i++) begin
            stub_lat = i % 3;
            push_cmd(tbl[i].op, tbl[i].x, tbl[i].y, 1'b1, tbl[i].exp);
            drain("tbl_drain");
        end

        // Ordering: four queued adds, back-to-back issue spacing.
        stub_lat = 0;
        go_edges.delete();
        g0 = go_total;
        for (int i = 0; i < 4; i++) push_cmd(2'd0, 4'(i), 4'd1, 1'b1, 4'(i + 1));
        drain("order_drain");
        chk("order_go_count", go_total - g0, 4);
        if (go_edges.size() >= 4)
            for (int i = 0; i < 3; i++) chk("order_go_gap", go_edges[i + 1] - go_edges[i], 4);

        // Backpressure: result held for 10 cycles with res_ready low.
        bus.res_ready = 1'b0;
        push_cmd(2'd0, 4'd5, 4'd6, 1'b1, 4'd11);
        push_cmd(2'd1, 4'd9, 4'd2, 1'b1, 4'd7);
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_seen", {31'd0, bus.res_valid}, 1);
        g0 = go_total;
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", {31'd0, bus.res_valid}, 1);
            chk("bp_res_data", {28'd0, bus.res_data}, 11);
            chk("bp_go", {31'd0, bus.go_calc}, 0);
            @(negedge clk);
        end
        chk("bp_go_total", go_total, g0);
        chk("bp_count", {29'd0, bus.count}, 1);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'd0, bus.res_valid}, 0);
        chk("bp_release_idle_go", {31'd0, bus.go_calc}, 0);
        @(negedge clk);
        chk("bp_next_issue_go", {31'd0, bus.go_calc}, 1);
        @(posedge clk);
        #1;
        drain("bp_drain");

        // Burst fill with a calculator that never completes.
        stub_en = 1'b0;
        go_edges.delete();
        acc = 0; maxc = 0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_op = 2'd2; bus.cmd_x = 4'(i); bus.cmd_y = 4'd7;
            @(negedge clk);
            if (bus.cmd_ready) acc++;
            if (int'(bus.count) > maxc) maxc = int'(bus.count);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("burst_accepted", acc, 4);
        chk("burst_count", {29'd0, bus.count}, 4);
        chk("burst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
        chk("burst_max_count", maxc, 4);

        // Watchdog timeout drops the head entry and the next one issues.
        n = 0;
        while (!bus.timeout_err && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("to_seen", {31'd0, bus.timeout_err}, 1);
        if (go_edges.size() > 0) chk("to_edge", cyc - go_edges[0], WAIT_LIMIT + 1);
        chk("to_count", {29'd0, bus.count}, 3);
        chk("to_idle_go", {31'd0, bus.go_calc}, 0);
        @(negedge clk);
        chk("to_next_go", {31'd0, bus.go_calc}, 1);
        chk("to_next_calc_x", {28'd0, bus.calc_x}, 1);

        // Reset while in WAIT with three entries queued.
        @(posedge clk);
        #1;
        chk("pre_rst_count", {29'd0, bus.count}, 3);
        rst = 1'b1;
        #1;
        check_reset("mid_wait_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        g0 = go_total;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_go", go_total, g0);
        chk("post_rst_count", {29'd0, bus.count}, 0);
        @(posedge clk);
        #1;
        stub_en = 1'b1;
        push_cmd(2'd1, 4'd2, 4'd7, 1'b1, 4'd11);
        drain("post_rst_drain");
        chk("post_rst_go_count", go_total - g0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
